// File: rtl/sobel_frame_sched_if.sv
// rtl/sobel_frame_sched_if.sv - host-side pixel streams of the Sobel frame scheduler
// Purpose: bundles the input-pixel load stream and the output-pixel stream.
// Signals:
//   ld_valid/ld_ready/ld_data      host -> scheduler input pixels
//   st_valid/st_ready/st_data/st_last  scheduler -> host output pixels
// Modports: master = host side, slave = scheduler side.
interface sobel_frame_sched_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  ld_valid;
  logic                  ld_ready;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  st_valid;
  logic                  st_ready;
  logic [DATA_WIDTH-1:0] st_data;
  logic                  st_last;

  modport master (
    output ld_valid, ld_data, st_ready,
    input  ld_ready, st_valid, st_data, st_last
  );

  modport slave (
    input  ld_valid, ld_data, st_ready,
    output ld_ready, st_valid, st_data, st_last
  );
endinterface

// File: rtl/sobel_frame_sched.sv
// rtl/sobel_frame_sched.sv - frame scheduler: load input frame, run Sobel engine, drain output frame
// Purpose: sequences IDLE -> LOAD -> KICK -> RUN -> DRAIN and muxes the single-port input/output
//   image memories between host-side logic and the engine.
// Optional feature: SOBEL_SCHED_WDT_EN enables a RUN-phase watchdog (WDT_CYCLES) driving sticky err_o.
// Ports:
//   clk_i, rst_ni                      clock, synchronous active-low reset
//   frame_start_i                      frame request, sampled in IDLE
//   host (slave modport)               load stream in, output pixel stream out
//   in_we_o/in_addr_o/in_wdata_o       input memory port
//   sobel_raddr_i, sobel_start_o, sobel_finish_i, sobel_we_i/waddr_i/wdata_i   engine side
//   out_we_o/out_addr_o/out_wdata_o/out_rdata_i   output memory port (1-cycle read latency)
//   busy_o, frame_cnt_o, err_o         status
module sobel_frame_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int IMG_PIXELS = 4096,
  parameter int WDT_CYCLES = 65535
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  frame_start_i,
  sobel_frame_sched_if.slave    host,
  output logic                  in_we_o,
  output logic [ADDR_WIDTH-1:0] in_addr_o,
  output logic [DATA_WIDTH-1:0] in_wdata_o,
  input  logic [ADDR_WIDTH-1:0] sobel_raddr_i,
  output logic                  sobel_start_o,
  input  logic                  sobel_finish_i,
  input  logic                  sobel_we_i,
  input  logic [ADDR_WIDTH-1:0] sobel_waddr_i,
  input  logic [DATA_WIDTH-1:0] sobel_wdata_i,
  output logic                  out_we_o,
  output logic [ADDR_WIDTH-1:0] out_addr_o,
  output logic [DATA_WIDTH-1:0] out_wdata_o,
  input  logic [DATA_WIDTH-1:0] out_rdata_i,
  output logic                  busy_o,
  output logic [15:0]           frame_cnt_o,
  output logic                  err_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(IMG_PIXELS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_KICK, S_RUN, S_DRAIN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] lc;          // load counter
  logic [ADDR_WIDTH-1:0] rc;          // next output-memory index to read
  logic [ADDR_WIDTH-1:0] pidx;        // index whose read data is on out_rdata_i this cycle
  logic                  pending;     // out_rdata_i carries a valid read this cycle
  logic                  issue_done;  // all indices have been issued
  logic                  ld_ready_r;
  logic                  st_valid_r;
  logic                  st_last_r;
  logic [DATA_WIDTH-1:0] st_data_r;
  logic                  start_r;
  logic                  busy_r;
  logic [15:0]           frame_cnt_r;

  logic ld_beat, accept, capture, stall, issue;

  always_comb begin
    ld_beat = (state == S_LOAD) && host.ld_valid && ld_ready_r;
    accept  = st_valid_r && host.st_ready;
    // Read data is taken into the holding register only if it is empty or drains this cycle.
    capture = pending && (!st_valid_r || host.st_ready);
    // A read that cannot be captured is repeated at the same address so its data reappears next cycle.
    stall   = pending && !capture;
    issue   = (state == S_DRAIN) && !stall && !issue_done;
  end

  always_comb begin
    in_we_o     = ld_beat;
    in_addr_o   = (state == S_LOAD) ? lc : sobel_raddr_i;
    in_wdata_o  = (state == S_LOAD) ? host.ld_data : '0;
    out_we_o    = 1'b0;
    out_addr_o  = '0;
    out_wdata_o = '0;
    if (state == S_RUN) begin
      out_we_o    = sobel_we_i;
      out_addr_o  = sobel_waddr_i;
      out_wdata_o = sobel_wdata_i;
    end else if (state == S_DRAIN) begin
      out_addr_o  = stall ? pidx : rc;
    end
  end

`ifdef SOBEL_SCHED_WDT_EN
  logic [31:0] wdt;
  logic        err_r;
`else
  logic        unused_wdt;
  assign unused_wdt = (WDT_CYCLES == 0);
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      lc          <= '0;
      rc          <= '0;
      pidx        <= '0;
      pending     <= 1'b0;
      issue_done  <= 1'b0;
      ld_ready_r  <= 1'b0;
      st_valid_r  <= 1'b0;
      st_last_r   <= 1'b0;
      st_data_r   <= '0;
      start_r     <= 1'b0;
      busy_r      <= 1'b0;
      frame_cnt_r <= '0;
`ifdef SOBEL_SCHED_WDT_EN
      wdt         <= '0;
      err_r       <= 1'b0;
`endif
    end else begin
      start_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_start_i) begin
            state      <= S_LOAD;
            lc         <= '0;
            ld_ready_r <= 1'b1;
            busy_r     <= 1'b1;
          end
        end
        S_LOAD: begin
          if (ld_beat) begin
            if (lc == LAST) begin
              state      <= S_KICK;
              ld_ready_r <= 1'b0;
              start_r    <= 1'b1;
            end else begin
              lc <= lc + 1'b1;
            end
          end
        end
        S_KICK: begin
          state <= S_RUN;
`ifdef SOBEL_SCHED_WDT_EN
          wdt   <= '0;
`endif
        end
        S_RUN: begin
          if (sobel_finish_i) begin
            state      <= S_DRAIN;
            rc         <= '0;
            pending    <= 1'b0;
            issue_done <= 1'b0;
            st_valid_r <= 1'b0;
            st_last_r  <= 1'b0;
`ifdef SOBEL_SCHED_WDT_EN
          end else if (wdt == 32'(WDT_CYCLES - 1)) begin
            state  <= S_IDLE;
            busy_r <= 1'b0;
            err_r  <= 1'b1;
          end else begin
            wdt <= wdt + 1'b1;
`endif
          end
        end
        S_DRAIN: begin
          if (capture) begin
            st_data_r  <= out_rdata_i;
            st_valid_r <= 1'b1;
            st_last_r  <= (pidx == LAST);
          end else if (accept) begin
            st_valid_r <= 1'b0;
            st_last_r  <= 1'b0;
          end
          pending <= stall || issue;
          if (!stall) pidx <= rc;
          if (issue) begin
            if (rc == LAST) issue_done <= 1'b1;
            else            rc <= rc + 1'b1;
          end
          if (accept && st_last_r) begin
            state       <= S_IDLE;
            busy_r      <= 1'b0;
            frame_cnt_r <= frame_cnt_r + 1'b1;
            pending     <= 1'b0;
            st_valid_r  <= 1'b0;
            st_last_r   <= 1'b0;
            st_data_r   <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign host.ld_ready = ld_ready_r;
  assign host.st_valid = st_valid_r;
  assign host.st_data  = st_data_r;
  assign host.st_last  = st_valid_r && st_last_r;
  assign sobel_start_o = start_r;
  assign busy_o        = busy_r;
  assign frame_cnt_o   = frame_cnt_r;
`ifdef SOBEL_SCHED_WDT_EN
  assign err_o         = err_r;
`else
  assign err_o         = 1'b0;
`endif

endmodule

// File: tb/tb_sobel_frame_sched.sv
// tb/tb_sobel_frame_sched.sv - scoreboard testbench for sobel_frame_sched
module tb_sobel_frame_sched;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int NPIX = 16;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic          frame_start;
  logic          in_we, sobel_start, sobel_finish, sobel_we, out_we, busy, err;
  logic [AW-1:0] in_addr, sobel_raddr, sobel_waddr, out_addr;
  logic [DW-1:0] in_wdata, sobel_wdata, out_wdata, out_rdata;
  logic [15:0]   frame_cnt;

  sobel_frame_sched_if #(.DATA_WIDTH(DW)) hif ();

  sobel_frame_sched #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMG_PIXELS(NPIX), .WDT_CYCLES(50)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .frame_start_i(frame_start), .host(hif),
    .in_we_o(in_we), .in_addr_o(in_addr), .in_wdata_o(in_wdata),
    .sobel_raddr_i(sobel_raddr), .sobel_start_o(sobel_start), .sobel_finish_i(sobel_finish),
    .sobel_we_i(sobel_we), .sobel_waddr_i(sobel_waddr), .sobel_wdata_i(sobel_wdata),
    .out_we_o(out_we), .out_addr_o(out_addr), .out_wdata_o(out_wdata), .out_rdata_i(out_rdata),
    .busy_o(busy), .frame_cnt_o(frame_cnt), .err_o(err)
  );

  logic [7:0] in_mem [NPIX];
  logic [7:0] out_mem [NPIX];
  always @(posedge clk) begin
    if (in_we) in_mem[in_addr[3:0]] <= in_wdata;
    if (out_we) out_mem[out_addr[3:0]] <= out_wdata;
    out_rdata <= out_mem[out_addr[3:0]];
  end

  // Expected output frames: output memory preloaded with A0+i, then engine overwrites.
  logic [7:0] f1_exp [NPIX] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hFF, 8'hA6, 8'hA7,
                                8'hA8, 8'hA9, 8'hAA, 8'hAB, 8'hAC, 8'hAD, 8'hAE, 8'hAF};
  logic [7:0] f2_exp [NPIX] = '{8'hA0, 8'hA1, 8'hA2, 8'h3C, 8'hA4, 8'hFF, 8'hA6, 8'hA7,
                                8'hA8, 8'hA9, 8'hAA, 8'hAB, 8'hAC, 8'hAD, 8'hAE, 8'hAF};

  typedef struct { logic [15:0] a; logic [7:0] d; } wr_t;
  typedef struct { logic [7:0] d; logic l; } st_t;
  wr_t exp_wr[$];
  st_t exp_st[$];

  int checks = 0, errors = 0, cyc = 0;
  int start_cnt = 0, start_cyc = 0, last_wr_cyc = 0;
  int beats = 0, first_beat_cyc = 0, last_beat_cyc = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes input memory or hands over a pixel.
  always @(negedge clk) begin
    if (!rst_ni) begin
      prev_stall = 1'b0;
    end else begin
      if (in_we) begin
        chk("wr_expected", exp_wr.size() > 0, 1);
        if (exp_wr.size() > 0) begin
          wr_t w;
          w = exp_wr.pop_front();
          chk("wr_addr", in_addr, w.a);
          chk("wr_data", in_wdata, w.d);
        end
        if (in_addr == 16'(NPIX - 1)) last_wr_cyc = cyc;
      end
      if (sobel_start) begin
        start_cnt++;
        start_cyc = cyc;
      end
      if (prev_stall) begin
        chk("stall_valid", hif.st_valid, 1);
        chk("stall_data", hif.st_data, prev_data);
      end
      if (hif.st_valid && hif.st_ready) begin
        chk("st_expected", exp_st.size() > 0, 1);
        if (exp_st.size() > 0) begin
          st_t s;
          s = exp_st.pop_front();
          chk("st_data", hif.st_data, s.d);
          chk("st_last", hif.st_last, s.l);
        end
        if (beats == 0) first_beat_cyc = cyc;
        if (hif.st_last) last_beat_cyc = cyc;
        beats++;
      end
      prev_stall = hif.st_valid && !hif.st_ready;
      prev_data  = hif.st_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requests a frame, loads NPIX pixels with gaps, checks the start pulse; ends in the first RUN cycle.
  task automatic do_load(input logic [7:0] base);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    @(negedge clk);
    chk("load_busy", busy, 1);
    chk("load_ld_ready", hif.ld_ready, 1);
    chk("load_no_start", sobel_start, 0);
    for (int i = 0; i < NPIX; i++) begin
      if (i % 3 == 1) begin
        hif.ld_valid = 1'b0;
        tick();
      end
      hif.ld_valid = 1'b1;
      hif.ld_data  = base + 8'(i);
      exp_wr.push_back('{a: 16'(i), d: base + 8'(i)});
      tick();
    end
    hif.ld_valid = 1'b0;
    @(negedge clk);
    chk("kick_start", sobel_start, 1);
    chk("kick_ld_ready", hif.ld_ready, 0);
    tick();
    @(negedge clk);
    chk("run_start_low", sobel_start, 0);
  endtask

  task automatic drain(input logic [15:0] target, input bit rnd);
    for (int n = 0; n < 400 && frame_cnt != target; n++) begin
      tick();
      if (rnd) hif.st_ready = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    chk("frame_cnt", frame_cnt, target);
    chk("drain_idle", busy, 0);
    chk("st_queue_empty", exp_st.size(), 0);
    chk("beats", beats, NPIX);
  endtask

  initial begin
    frame_start = 0; hif.ld_valid = 0; hif.ld_data = 0; hif.st_ready = 0;
    sobel_raddr = 0; sobel_finish = 0; sobel_we = 0; sobel_waddr = 0; sobel_wdata = 0;
    for (int i = 0; i < NPIX; i++) out_mem[i] = 8'hA0 + 8'(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ld_ready", hif.ld_ready, 0);
    chk("rst_st_valid", hif.st_valid, 0);
    chk("rst_st_last", hif.st_last, 0);
    chk("rst_st_data", hif.st_data, 0);
    chk("rst_start", sobel_start, 0);
    chk("rst_in_we", in_we, 0);
    chk("rst_out_we", out_we, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_err", err, 0);
    tick();
    rst_ni = 1'b1;

    // A finish pulse in IDLE must not start anything.
    sobel_finish = 1'b1;
    tick();
    sobel_finish = 1'b0;
    @(negedge clk);
    chk("idle_finish_ignored", busy, 0);

    // Frame 1: gapped load, engine write pass-through, full-rate drain.
    do_load(8'h00);
    chk("start_count", start_cnt, 1);
    chk("start_timing", start_cyc, last_wr_cyc + 1);
    tick();
    sobel_we = 1'b1; sobel_waddr = 16'd5; sobel_wdata = 8'hFF; sobel_raddr = 16'd7;
    @(negedge clk);
    chk("run_out_we", out_we, 1);
    chk("run_out_addr", out_addr, 5);
    chk("run_out_wdata", out_wdata, 8'hFF);
    chk("run_in_addr", in_addr, 7);
    tick();
    sobel_we = 1'b0; sobel_raddr = 0;
    for (int i = 0; i < NPIX; i++) exp_st.push_back('{d: f1_exp[i], l: (i == NPIX - 1)});
    beats = 0;
    hif.st_ready = 1'b1;
    sobel_finish = 1'b1;
    tick();
    sobel_finish = 1'b0;
    drain(16'd1, 1'b0);
    chk("drain_consecutive", last_beat_cyc - first_beat_cyc, NPIX - 1);
    chk("in_mem_15", in_mem[15], 8'h0F);

    // Frame 2: engine write to addr 3, drain with random back-pressure.
    do_load(8'h40);
    sobel_we = 1'b1; sobel_waddr = 16'd3; sobel_wdata = 8'h3C;
    tick();
    sobel_we = 1'b0;
    for (int i = 0; i < NPIX; i++) exp_st.push_back('{d: f2_exp[i], l: (i == NPIX - 1)});
    beats = 0;
    hif.st_ready = 1'b0;
    sobel_finish = 1'b1;
    tick();
    sobel_finish = 1'b0;
    drain(16'd2, 1'b1);

`ifdef SOBEL_SCHED_WDT_EN
    // Watchdog: no finish; err rises at the end of RUN cycle 50.
    do_load(8'h80);
    repeat (49) tick();
    @(negedge clk);
    chk("wdt_err_before", err, 0);
    chk("wdt_busy_before", busy, 1);
    tick();
    @(negedge clk);
    chk("wdt_err", err, 1);
    chk("wdt_idle", busy, 0);
    chk("wdt_frame_cnt", frame_cnt, 2);
`endif

    // Frame 3: stall in DRAIN, then reset aborts the frame.
    do_load(8'hC0);
    hif.st_ready = 1'b0;
    sobel_finish = 1'b1;
    tick();
    sobel_finish = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    chk("held_valid", hif.st_valid, 1);
    rst_ni = 1'b0;
    tick();
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_st_valid", hif.st_valid, 0);
    chk("abort_frame_cnt", frame_cnt, 0);
    chk("abort_err", err, 0);
    chk("abort_out_addr", out_addr, 0);
    rst_ni = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
